// File: rtl/lsu_wb_pipe_pkg.sv
// Shared RV load/store decode constants for the LSU writeback pipe.
//   F3_*    : funct3 encodings that need special handling in decode
//   SZ_*    : access size encodings taken from funct3[1:0]
//   size_mask(): byte mask for an access size, before lane shifting
package lsu_wb_pipe_pkg;

   localparam logic [2:0] F3_D   = 3'b011;   // LD / SD, XLEN=64 only
   localparam logic [2:0] F3_WU  = 3'b110;   // LWU, XLEN=64 only
   localparam logic [2:0] F3_ILL = 3'b111;   // never legal

   localparam int unsigned ZEXT_BIT = 2;     // funct3 bit selecting zero-extension

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // Unshifted byte-enable pattern for a given access size.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      m = 8'h00;
      case (sz)
         SZ_B: m = 8'h01;
         SZ_H: m = 8'h03;
         SZ_W: m = 8'h0F;
         SZ_D: m = 8'hFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_wb_pipe_if.sv
// Data-memory request/grant channel between the LSU and data memory.
//   mem_req/mem_gnt     : request handshake (master drives req)
//   mem_we/addr/be/wdata: request payload, word-aligned address
//   mem_rvalid/rdata    : in-order load responses (slave drives)
interface lsu_wb_pipe_if #(
   parameter int unsigned XLEN = 32
);
   localparam int unsigned NB = XLEN / 8;

   logic            mem_req;
   logic            mem_gnt;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [NB-1:0]   mem_be;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_wb_pipe_fifo.sv
// Outstanding-load tracker: DEPTH-entry FIFO of {rd, f3, offset}.
//   clk, rst        : clock, synchronous active-high reset (clears pointers/count)
//   push, push_data : enqueue when not full
//   pop             : dequeue when not empty
//   head            : oldest entry
//   full, empty     : occupancy flags
module lsu_fifo #(
   parameter int unsigned W     = 11,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   // Pointer advance with explicit wrap so DEPTH=1 stays at index 0.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem_q[rd_ptr];

   // Pointer and occupancy state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entry storage; contents are only meaningful while counted.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/lsu_wb_pipe.sv
// Load/store unit with registered writeback for an RV32/RV64 datapath.
//   clk, rst      : clock, synchronous active-high reset
//   in_*          : EX op (valid/ready), load/store, funct3, address, store data, rd
//   mem_bus       : data-memory request/grant and in-order load response channel
//   wb_en/reg/val : registered writeback, strobe one cycle after a response
//   misalign      : one-cycle pulse after a misaligned/illegal op is dropped
//   bad_addr      : address of the most recent dropped op
//   rsp_err       : sticky, a response arrived with no load outstanding
module lsu_wb_pipe
   import lsu_wb_pipe_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned RAW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_load,
   input  logic [2:0]      in_f3,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [RAW-1:0]  in_rd,
   lsu_wb_pipe_if.master   mem_bus,
   output logic            wb_en,
   output logic [RAW-1:0]  wb_reg,
   output logic [XLEN-1:0] wb_val,
   output logic            misalign,
   output logic [XLEN-1:0] bad_addr,
   output logic            rsp_err
);
   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned EW = RAW + 6;

   logic [OW-1:0]   off;
   logic [2:0]      off3;
   logic [1:0]      sz;
   logic            legal;
   logic            aligned;
   logic            ok;
   logic            misaligned;
   logic            req_c;
   logic            push;
   logic            fifo_full;
   logic            fifo_empty;
   logic [EW-1:0]   push_data;
   logic [EW-1:0]   head;
   logic [RAW-1:0]  h_rd;
   logic [2:0]      h_f3;
   logic [2:0]      h_off;
   logic [XLEN-1:0] ld_data;

   // Truncate a lane-aligned load word to its size and sign/zero-extend.
   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
      logic [XLEN-1:0] r;
      r = d;
      case (f3[1:0])
         SZ_B: begin
            if (f3[ZEXT_BIT]) r = XLEN'(d[7:0]);
            else              r = XLEN'($signed(d[7:0]));
         end
         SZ_H: begin
            if (f3[ZEXT_BIT]) r = XLEN'(d[15:0]);
            else              r = XLEN'($signed(d[15:0]));
         end
         SZ_W: begin
            if (f3[ZEXT_BIT]) r = XLEN'(d[31:0]);
            else              r = XLEN'($signed(d[31:0]));
         end
         SZ_D: r = d;
      endcase
      return r;
   endfunction

   assign off  = in_addr[OW-1:0];
   assign off3 = 3'(off);
   assign sz   = in_f3[1:0];

   // Decode legality and natural alignment of the incoming op.
   always_comb begin
      legal = (in_f3 != F3_ILL);
      if ((XLEN == 32) && ((in_f3 == F3_D) || (in_f3 == F3_WU))) legal = 1'b0;
      aligned = 1'b1;
      case (sz)
         SZ_B: aligned = 1'b1;
         SZ_H: aligned = (off3[0] == 1'b0);
         SZ_W: aligned = (off3[1:0] == 2'b00);
         SZ_D: aligned = (off3 == 3'b000);
      endcase
   end

   assign ok         = legal & aligned;
   assign misaligned = in_valid & ~ok;

   // A full tracker stalls loads even when a response frees a slot this cycle.
   assign req_c = ~rst & in_valid & ok & (~in_load | ~fifo_full);
   assign push  = req_c & mem_bus.mem_gnt & in_load;

   assign push_data          = {in_rd, in_f3, off3};
   assign {h_rd, h_f3, h_off} = head;
   assign ld_data            = extend(mem_bus.mem_rdata >> {h_off, 3'b000}, h_f3);

   // Request payload and EX handshake; everything forced low under reset.
   always_comb begin
      in_ready          = 1'b0;
      mem_bus.mem_req   = 1'b0;
      mem_bus.mem_we    = 1'b0;
      mem_bus.mem_addr  = '0;
      mem_bus.mem_be    = '0;
      mem_bus.mem_wdata = '0;
      if (!rst) begin
         in_ready          = (req_c & mem_bus.mem_gnt) | misaligned;
         mem_bus.mem_req   = req_c;
         mem_bus.mem_we    = req_c & ~in_load;
         mem_bus.mem_addr  = {in_addr[XLEN-1:OW], OW'(0)};
         mem_bus.mem_be    = NB'(size_mask(sz)) << off;
         mem_bus.mem_wdata = in_wdata << {off, 3'b000};
      end
   end

   lsu_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (mem_bus.mem_rvalid),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Writeback, misalign pulse and response-error tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en    <= 1'b0;
         wb_reg   <= '0;
         wb_val   <= '0;
         misalign <= 1'b0;
         bad_addr <= '0;
         rsp_err  <= 1'b0;
      end else begin
         wb_en    <= 1'b0;
         misalign <= 1'b0;
         if (mem_bus.mem_rvalid) begin
            if (!fifo_empty) begin
               wb_en  <= (h_rd != '0);
               wb_reg <= h_rd;
               wb_val <= ld_data;
            end else begin
               rsp_err <= 1'b1;
            end
         end
         if (misaligned) begin
            misalign <= 1'b1;
            bad_addr <= in_addr;
         end
      end
   end

endmodule

// File: tb/tb_lsu_wb_pipe.sv
// Self-checking bench for lsu_wb_pipe: directed scenarios on an RV32 and an
// RV64 instance, then randomized traffic against a queue-based reference model.
module tb_lsu_wb_pipe;

   typedef struct {
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [63:0] addr;
   } pend_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   lsu_wb_pipe_if #(.XLEN(32)) bus32 ();
   lsu_wb_pipe_if #(.XLEN(64)) bus64 ();

   logic        a_valid, a_ready, a_load, a_wb_en, a_mis, a_err;
   logic [2:0]  a_f3;
   logic [31:0] a_addr, a_wdata, a_wb_val, a_bad;
   logic [4:0]  a_rd, a_wb_reg;

   logic        b_valid, b_ready, b_load, b_wb_en, b_mis, b_err;
   logic [2:0]  b_f3;
   logic [63:0] b_addr, b_wdata, b_wb_val, b_bad;
   logic [4:0]  b_rd, b_wb_reg;

   lsu_wb_pipe #(.XLEN(32), .DEPTH(2), .RAW(5)) dut32 (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_load(a_load),
      .in_f3(a_f3), .in_addr(a_addr), .in_wdata(a_wdata), .in_rd(a_rd), .mem_bus(bus32),
      .wb_en(a_wb_en), .wb_reg(a_wb_reg), .wb_val(a_wb_val), .misalign(a_mis),
      .bad_addr(a_bad), .rsp_err(a_err)
   );

   lsu_wb_pipe #(.XLEN(64), .DEPTH(2), .RAW(5)) dut64 (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_load(b_load),
      .in_f3(b_f3), .in_addr(b_addr), .in_wdata(b_wdata), .in_rd(b_rd), .mem_bus(bus64),
      .wb_en(b_wb_en), .wb_reg(b_wb_reg), .wb_val(b_wb_val), .misalign(b_mis),
      .bad_addr(b_bad), .rsp_err(b_err)
   );

   logic        s_ready, s_req, s_we, s_wb_en, s_mis, s_err;
   logic [63:0] s_addr, s_be, s_wdata, s_wb_val, s_bad;
   logic [4:0]  s_wb_reg;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int xw, input logic v, input logic ld, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                      input logic gnt, input logic rv, input logic [63:0] rdata);
      if (xw == 32) begin
         a_valid = v; a_load = ld; a_f3 = f3; a_addr = addr[31:0]; a_wdata = wdata[31:0];
         a_rd = rd; bus32.mem_gnt = gnt; bus32.mem_rvalid = rv; bus32.mem_rdata = rdata[31:0];
      end else begin
         b_valid = v; b_load = ld; b_f3 = f3; b_addr = addr; b_wdata = wdata;
         b_rd = rd; bus64.mem_gnt = gnt; bus64.mem_rvalid = rv; bus64.mem_rdata = rdata;
      end
   endtask

   task automatic idle(input int xw);
      drv(xw, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic sample(input int xw);
      if (xw == 32) begin
         s_ready = a_ready; s_req = bus32.mem_req; s_we = bus32.mem_we;
         s_addr = 64'(bus32.mem_addr); s_be = 64'(bus32.mem_be); s_wdata = 64'(bus32.mem_wdata);
         s_wb_en = a_wb_en; s_wb_reg = a_wb_reg; s_wb_val = 64'(a_wb_val);
         s_mis = a_mis; s_bad = 64'(a_bad); s_err = a_err;
      end else begin
         s_ready = b_ready; s_req = bus64.mem_req; s_we = bus64.mem_we;
         s_addr = bus64.mem_addr; s_be = 64'(bus64.mem_be); s_wdata = bus64.mem_wdata;
         s_wb_en = b_wb_en; s_wb_reg = b_wb_reg; s_wb_val = b_wb_val;
         s_mis = b_mis; s_bad = b_bad; s_err = b_err;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(32);
      idle(64);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reference rules: legality, natural alignment, and load-value extraction.
   function automatic bit is_ok(input int xw, input logic [2:0] f3, input logic [63:0] a);
      if (f3 == 3'b111) return 1'b0;
      if (xw == 32 && (f3 == 3'b011 || f3 == 3'b110)) return 1'b0;
      return (a % 64'(1 << f3[1:0])) == 64'd0;
   endfunction

   function automatic logic [63:0] ld_val(input int xw, input logic [2:0] f3,
                                          input logic [63:0] a, input logic [63:0] rdata);
      int nb, off, n;
      logic [63:0] v, m;
      nb  = xw / 8;
      off = int'(a % 64'(nb));
      n   = 1 << f3[1:0];
      v   = rdata >> (8 * off);
      if (n < 8) begin
         m = (64'd1 << (8 * n)) - 64'd1;
         v = v & m;
         if (!f3[2] && v[8*n-1]) v = v | ~m;
      end
      if (xw == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic rand_run(input int xw, input int n);
      pend_t       q[$];
      pend_t       h;
      logic        v, ld, gnt, rv, ok, e_req, e_ready, e_en, e_mis;
      logic [2:0]  f3;
      logic [4:0]  rd, e_reg;
      logic [63:0] addr, wdata, rdata, xmask, e_val;
      int          nb, off, nsz;
      xmask = (xw == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      nb    = xw / 8;
      for (int i = 0; i < n; i++) begin
         v     = ($urandom_range(0, 9) < 7);
         ld    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         rd    = 5'($urandom_range(0, 31));
         nsz   = 1 << f3[1:0];
         addr  = {32'($urandom), 32'($urandom)} & xmask;
         if ($urandom_range(0, 2) != 0) addr = addr & ~64'(nsz - 1);
         wdata = {32'($urandom), 32'($urandom)} & xmask;
         rdata = {32'($urandom), 32'($urandom)} & xmask;
         gnt   = ($urandom_range(0, 3) != 0);
         rv    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         ok    = is_ok(xw, f3, addr);
         e_req   = v && ok && (!ld || q.size() < 2);
         e_ready = (e_req && gnt) || (v && !ok);
         off   = int'(addr % 64'(nb));

         drv(xw, v, ld, f3, addr, wdata, rd, gnt, rv, rdata);
         #1;
         sample(xw);
         check("rnd_req", 64'(s_req), 64'(e_req));
         check("rnd_ready", 64'(s_ready), 64'(e_ready));
         if (e_req) begin
            check("rnd_we", 64'(s_we), 64'(!ld));
            check("rnd_addr", s_addr, addr & ~64'(nb - 1));
            check("rnd_be", s_be, ((64'd1 << nsz) - 64'd1) << off);
            if (!ld) check("rnd_wdata", s_wdata, (wdata << (8 * off)) & xmask);
         end

         e_en  = 1'b0;
         e_reg = 5'd0;
         e_val = 64'd0;
         e_mis = v && !ok;
         if (rv) begin
            h     = q.pop_front();
            e_en  = (h.rd != 5'd0);
            e_reg = h.rd;
            e_val = ld_val(xw, h.f3, h.addr, rdata);
         end
         if (e_req && gnt && ld) q.push_back('{rd, f3, addr});

         tick();
         sample(xw);
         check("rnd_wb_en", 64'(s_wb_en), 64'(e_en));
         if (rv) begin
            check("rnd_wb_reg", 64'(s_wb_reg), 64'(e_reg));
            check("rnd_wb_val", s_wb_val, e_val);
         end
         check("rnd_misalign", 64'(s_mis), 64'(e_mis));
         if (e_mis) check("rnd_bad_addr", s_bad, addr);
         check("rnd_rsp_err", 64'(s_err), 64'd0);
      end
      idle(xw);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle(64);
      // Live load presented during reset must be ignored.
      drv(32, 1'b1, 1'b1, 3'b010, 64'h100, 64'd0, 5'd1, 1'b1, 1'b0, 64'd0);
      tick();
      sample(32);
      check("rst_ready", 64'(s_ready), 64'd0);
      check("rst_req", 64'(s_req), 64'd0);
      check("rst_wb_en", 64'(s_wb_en), 64'd0);
      check("rst_wb_reg", 64'(s_wb_reg), 64'd0);
      check("rst_wb_val", s_wb_val, 64'd0);
      check("rst_misalign", 64'(s_mis), 64'd0);
      check("rst_bad_addr", s_bad, 64'd0);
      check("rst_rsp_err", 64'(s_err), 64'd0);
      idle(32);
      rst = 1'b0;
      tick();

      // LB from byte 3 sign-extends.
      drv(32, 1'b1, 1'b1, 3'b000, 64'h1003, 64'd0, 5'd7, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("lb_req", 64'(s_req), 64'd1);
      check("lb_ready", 64'(s_ready), 64'd1);
      check("lb_addr", s_addr, 64'h1000);
      check("lb_be", s_be, 64'h8);
      check("lb_we", 64'(s_we), 64'd0);
      tick();
      drv(32, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h80FF_1234);
      #1; sample(32);
      check("lb_wb_early", 64'(s_wb_en), 64'd0);
      tick(); sample(32);
      check("lb_wb_en", 64'(s_wb_en), 64'd1);
      check("lb_wb_reg", 64'(s_wb_reg), 64'd7);
      check("lb_wb_val", s_wb_val, 64'hFFFF_FF80);
      idle(32);
      tick(); sample(32);
      check("lb_wb_drop", 64'(s_wb_en), 64'd0);
      check("lb_wb_hold", s_wb_val, 64'hFFFF_FF80);

      // SH to upper half.
      drv(32, 1'b1, 1'b0, 3'b001, 64'h2002, 64'h0000_BEEF, 5'd3, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("sh_req", 64'(s_req), 64'd1);
      check("sh_ready", 64'(s_ready), 64'd1);
      check("sh_we", 64'(s_we), 64'd1);
      check("sh_be", s_be, 64'hC);
      check("sh_wdata", s_wdata, 64'hBEEF_0000);
      tick(); idle(32); #1; sample(32);
      check("sh_no_wb", 64'(s_wb_en), 64'd0);

      // Misaligned LW is dropped and reported.
      drv(32, 1'b1, 1'b1, 3'b010, 64'h2001, 64'd0, 5'd4, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("mis_ready", 64'(s_ready), 64'd1);
      check("mis_req", 64'(s_req), 64'd0);
      tick(); idle(32); #1; sample(32);
      check("mis_pulse", 64'(s_mis), 64'd1);
      check("mis_bad", s_bad, 64'h2001);
      tick(); sample(32);
      check("mis_pulse_end", 64'(s_mis), 64'd0);
      check("mis_bad_hold", s_bad, 64'h2001);

      // LD is illegal on RV32.
      drv(32, 1'b1, 1'b1, 3'b011, 64'h4000, 64'd0, 5'd4, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("ill_req", 64'(s_req), 64'd0);
      check("ill_ready", 64'(s_ready), 64'd1);
      tick(); idle(32); #1; sample(32);
      check("ill_pulse", 64'(s_mis), 64'd1);
      check("ill_bad", s_bad, 64'h4000);

      // Three back-to-back loads with DEPTH=2: third stalls until a response.
      drv(32, 1'b1, 1'b1, 3'b010, 64'h100, 64'd0, 5'd1, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("full_l1_ready", 64'(s_ready), 64'd1);
      tick();
      drv(32, 1'b1, 1'b1, 3'b101, 64'h106, 64'd0, 5'd2, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("full_l2_ready", 64'(s_ready), 64'd1);
      tick();
      drv(32, 1'b1, 1'b1, 3'b000, 64'h109, 64'd0, 5'd3, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("full_l3_ready", 64'(s_ready), 64'd0);
      check("full_l3_req", 64'(s_req), 64'd0);
      tick(); sample(32);
      check("full_l3_hold", 64'(s_ready), 64'd0);
      drv(32, 1'b1, 1'b1, 3'b000, 64'h109, 64'd0, 5'd3, 1'b1, 1'b1, 64'hDEAD_BEEF);
      #1; sample(32);
      check("full_pop_blocks", 64'(s_ready), 64'd0);
      tick(); sample(32);
      check("full_wb1_en", 64'(s_wb_en), 64'd1);
      check("full_wb1_reg", 64'(s_wb_reg), 64'd1);
      check("full_wb1_val", s_wb_val, 64'hDEAD_BEEF);
      drv(32, 1'b1, 1'b1, 3'b000, 64'h109, 64'd0, 5'd3, 1'b1, 1'b0, 64'd0);
      #1; sample(32);
      check("full_l3_issue", 64'(s_ready), 64'd1);
      check("full_l3_req1", 64'(s_req), 64'd1);
      tick();
      drv(32, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'hABCD_0000);
      tick(); sample(32);
      check("full_wb2_reg", 64'(s_wb_reg), 64'd2);
      check("full_wb2_val", s_wb_val, 64'h0000_ABCD);
      drv(32, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h0000_7F00);
      tick(); sample(32);
      check("full_wb3_reg", 64'(s_wb_reg), 64'd3);
      check("full_wb3_val", s_wb_val, 64'h0000_007F);

      // Response with nothing outstanding.
      drv(32, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h55);
      tick(); idle(32); #1; sample(32);
      check("err_wb_en", 64'(s_wb_en), 64'd0);
      check("err_set", 64'(s_err), 64'd1);
      tick(); sample(32);
      check("err_sticky", 64'(s_err), 64'd1);

      // Reset with two loads pending discards them.
      drv(32, 1'b1, 1'b1, 3'b010, 64'h200, 64'd0, 5'd4, 1'b1, 1'b0, 64'd0);
      tick();
      drv(32, 1'b1, 1'b1, 3'b010, 64'h204, 64'd0, 5'd5, 1'b1, 1'b0, 64'd0);
      tick();
      idle(32);
      rst = 1'b1;
      tick(); sample(32);
      check("mid_rst_err", 64'(s_err), 64'd0);
      check("mid_rst_wb_val", s_wb_val, 64'd0);
      check("mid_rst_wb_reg", 64'(s_wb_reg), 64'd0);
      check("mid_rst_bad", s_bad, 64'd0);
      rst = 1'b0;
      drv(32, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'h1234);
      tick(); idle(32); #1; sample(32);
      check("mid_rst_empty_wb", 64'(s_wb_en), 64'd0);
      check("mid_rst_empty_err", 64'(s_err), 64'd1);
      do_reset();

      // RV64: LWU from upper word zero-extends; SD covers all lanes.
      drv(64, 1'b1, 1'b1, 3'b110, 64'h3004, 64'd0, 5'd9, 1'b1, 1'b0, 64'd0);
      #1; sample(64);
      check("lwu_req", 64'(s_req), 64'd1);
      check("lwu_be", s_be, 64'hF0);
      check("lwu_addr", s_addr, 64'h3000);
      tick();
      drv(64, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000);
      tick(); sample(64);
      check("lwu_wb_en", 64'(s_wb_en), 64'd1);
      check("lwu_wb_reg", 64'(s_wb_reg), 64'd9);
      check("lwu_wb_val", s_wb_val, 64'h0000_0000_FFFF_FFFF);
      drv(64, 1'b1, 1'b0, 3'b011, 64'h3008, 64'h1122_3344_5566_7788, 5'd0, 1'b1, 1'b0, 64'd0);
      #1; sample(64);
      check("sd_we", 64'(s_we), 64'd1);
      check("sd_be", s_be, 64'hFF);
      check("sd_wdata", s_wdata, 64'h1122_3344_5566_7788);
      tick(); idle(64);

      rand_run(32, 300);
      do_reset();
      rand_run(64, 300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
